// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter.
// Duty, period and mode take effect only at period boundaries.
module pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 10,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  period,
    input  logic              center,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_duty,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              cycle_start
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] p_act;
    logic             center_act;
    logic             dir_down;
    logic             center_eff;
    logic             turn_down;
    logic             terminal;
    logic             wr_ok;
    logic [NUM_CH-1:0] wr_hit;

    logic [WIDTH-1:0] duty_pend [NUM_CH];
    logic [WIDTH-1:0] duty_act  [NUM_CH];

    // Counter sequencing: center mode needs at least 2 to have a distinct peak.
    always_comb begin
        center_eff = center_act && (p_act >= WIDTH'(2));
        turn_down  = center_eff && (dir_down || (cnt == p_act));
        terminal   = center_eff ? (dir_down && (cnt == WIDTH'(1))) : (cnt == p_act);
        if (terminal) begin
            cnt_next = '0;
        end else if (turn_down) begin
            cnt_next = cnt - WIDTH'(1);
        end else begin
            cnt_next = cnt + WIDTH'(1);
        end
        wr_ok = wr_en && (32'(wr_ch) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_ok && (32'(wr_ch) == 32'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dir_down    <= 1'b0;
            p_act       <= '0;
            center_act  <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            cycle_start <= terminal;
            if (terminal) begin
                dir_down   <= 1'b0;
                p_act      <= period;
                center_act <= center;
            end else if (turn_down) begin
                dir_down <= 1'b1;
            end
        end
    end

    // A write landing in the terminal cycle is forwarded straight into the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pend[i] <= '0;
                duty_act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= ch_en[i] && (cnt < duty_act[i]);
                if (wr_hit[i]) begin
                    duty_pend[i] <= wr_duty;
                end
                if (terminal) begin
                    duty_act[i] <= wr_hit[i] ? wr_duty : duty_pend[i];
                end
            end
        end
    end

endmodule
